id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-select stage that feeds the ALU. It captures decoded fields from the decode stage and forwards results from EX/MEM and MEM/WB to resolve RAW hazards. It detects load-use hazards and inserts one bubble, and applies flush and hold. Its outputs drive the ALU operands and `ALU_Control` directly, plus the control bits for later stages.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `REGW`, 5, register index width.

Ports (name, direction, width, meaning):
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `flush_i` in 1 — kill the instruction entering EX (branch taken).
- `hold_i` in 1 — downstream stall; freeze all state.
- `id_valid` in 1 — decode slot holds a real instruction.
- `id_rs1_data`, `id_rs2_data` in XLEN — register-file read data. The register file is write-first.
- `id_imm`, `id_pc` in XLEN — sign-extended immediate; instruction PC.
- `id_rs1`, `id_rs2`, `id_rd` in REGW — register indices.
- `id_alu_control` in 5 — ALU opcode (00000 add, 00010 sub, 11100 and, 10000 xor, 00100 sll, 10100 srl, 10110 sra, 11111 lui).
- `id_a_sel` in 2 — operand A: 00 rs1, 01 pc, 10 zero, 11 zero.
- `id_b_imm` in 1 — operand B from imm, else rs2.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch` in 1 — control bits.
- `exmem_reg_write` in 1, `exmem_rd` in REGW, `exmem_result` in XLEN — EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in REGW, `memwb_result` in XLEN — MEM/WB forwarding source.
- `ex_valid` out 1 — instruction in EX is real.
- `ex_rd1`, `ex_rd2` out XLEN, signed — ALU operands (combinational from state plus forwarding).
- `ex_alu_control` out 5 — registered ALU opcode.
- `ex_store_data` out XLEN — forwarded rs2, used for stores.
- `ex_pc` out XLEN; `ex_rd` out REGW — registered.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` out 1 — registered control.
- `hazard_stall` out 1 — combinational; tells fetch/decode to hold.

## Operation
- **Hazard detection (combinational):**
  - `hazard_stall` = `id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush_i`.
  - Both sources are compared unconditionally; conservative stalls are accepted.
- **Register update priority, per clock edge:**
  - Reset (`rst_n` = 0): all registered fields cleared to 0.
  - `flush_i`: load a bubble.
  - `hold_i`: keep all fields unchanged; `hazard_stall` still reflects the current state.
  - `hazard_stall`: load a bubble.
  - Otherwise: capture all `id_*` fields. `ex_valid` ← `id_valid`. If `id_valid` = 0, the control bits are captured as 0.
- **Bubble:** `valid`, `reg_write`, `mem_read`, `mem_write`, `branch` = 0; `alu_control` = 00000; data, index and pc fields = 0.
- **Forwarding (per source s in {rs1, rs2}, on the registered index):**
  - If `exmem_reg_write` and `exmem_rd != 0` and `exmem_rd == s`: use `exmem_result`.
  - Else if `memwb_reg_write` and `memwb_rd != 0` and `memwb_rd == s`: use `memwb_result`.
  - Else: use the registered data.
  - EX/MEM always wins over MEM/WB. x0 is never forwarded.
- **Operand selection:**
  - `ex_rd1`: forwarded rs1, pc, or 0 per `a_sel`.
  - `ex_rd2` = `b_imm` ? imm : forwarded rs2.
  - `ex_store_data` is always forwarded rs2.
- All arithmetic is pass-through; no width changes. XLEN bits everywhere.

## Timing
- Latency: one cycle from decode inputs to EX outputs.
- Forwarding mux is same-cycle: an EX/MEM or MEM/WB value present in cycle N appears on `ex_rd1`/`ex_rd2` in cycle N.
- Load-use costs exactly one bubble cycle. The consumer then forwards from MEM/WB.
- Reset values:
  - All registered outputs are 0.
  - `ex_rd1` = `ex_rd2` = `ex_store_data` = 0, since no forwarding match is possible on rd 0.
  - `hazard_stall` = 0 while `ex_valid` = 0.
- Reset mid-stall: the next cycle shows a bubble and `hazard_stall` = 0.
- `flush_i` together with `hazard_stall`: flush wins and `hazard_stall` is forced to 0.
- `flush_i` together with `hold_i`: flush wins.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with nonzero `id_*` → all outputs 0, `ex_alu_control` = 00000. After release, a valid add with rs1 data 5 and rs2 data 7 → next cycle `ex_rd1` = 5, `ex_rd2` = 7, `ex_alu_control` = 00000.
- **Forward priority:** EX holds rs1 = x3; `exmem_rd` = 3 with result 0x11; `memwb_rd` = 3 with result 0x22 → `ex_rd1` = 0x11. Drop `exmem_reg_write` → 0x22. Set `exmem_rd` = 0 with `exmem_reg_write` = 1 → no forwarding from EX/MEM.
- **Load-use:** lw x4 in EX, decode uses rs2 = x4 → `hazard_stall` = 1 for one cycle and the next EX is a bubble (`ex_valid` = 0, `ex_reg_write` = 0). The following cycle `ex_rd2` = `memwb_result` (0xDEAD0000).
- **Flush vs hazard:** a load-use condition with `flush_i` = 1 → `hazard_stall` = 0 and the next EX is a bubble.
- **Hold:** `hold_i` = 1 for 3 cycles while `id_*` change → EX fields unchanged. Forwarded operands still track the current EX/MEM and MEM/WB inputs.
- **LUI/immediate:** `a_sel` = 10, `b_imm` = 1, imm = 0x12345000, ctrl 11111 → `ex_rd1` = 0, `ex_rd2` = 0x12345000.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register plus the operand-select logic that feeds the ALU.
// Decoded fields are captured from the decode stage once per cycle. Results
// still in flight in EX/MEM and MEM/WB are forwarded onto the operands in the
// same cycle. A load followed directly by a consumer is detected here, and
// the stage inserts exactly one bubble for it.
//
// Ports:
//   clk, rst_n            - rising-edge clock, synchronous active-low reset
//   flush_i               - kill the instruction entering EX (branch taken)
//   hold_i                - downstream stall; freeze all registered state
//   id_*                  - decoded instruction fields from the decode stage
//   exmem_*               - EX/MEM forwarding source (write enable, rd, value)
//   memwb_*               - MEM/WB forwarding source (write enable, rd, value)
//   ex_valid              - the instruction in EX is real
//   ex_rd1, ex_rd2        - ALU operands (from registered state plus forwarding)
//   ex_alu_control        - registered ALU opcode
//   ex_store_data         - forwarded rs2 value for stores
//   ex_pc, ex_rd          - registered PC and destination index
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_branch - registered control
//   hazard_stall          - load-use hazard; fetch/decode must hold
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   hold_i,

    input  logic                   id_valid,
    input  logic [XLEN-1:0]        id_rs1_data,
    input  logic [XLEN-1:0]        id_rs2_data,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [REGW-1:0]        id_rs1,
    input  logic [REGW-1:0]        id_rs2,
    input  logic [REGW-1:0]        id_rd,
    input  logic [4:0]             id_alu_control,
    input  logic [1:0]             id_a_sel,
    input  logic                   id_b_imm,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic                   id_branch,

    input  logic                   exmem_reg_write,
    input  logic [REGW-1:0]        exmem_rd,
    input  logic [XLEN-1:0]        exmem_result,
    input  logic                   memwb_reg_write,
    input  logic [REGW-1:0]        memwb_rd,
    input  logic [XLEN-1:0]        memwb_result,

    output logic                   ex_valid,
    output logic signed [XLEN-1:0] ex_rd1,
    output logic signed [XLEN-1:0] ex_rd2,
    output logic [4:0]             ex_alu_control,
    output logic [XLEN-1:0]        ex_store_data,
    output logic [XLEN-1:0]        ex_pc,
    output logic [REGW-1:0]        ex_rd,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic                   ex_branch,
    output logic                   hazard_stall
);

    // Registered fields that are not themselves outputs
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [REGW-1:0] rs1_q;
    logic [REGW-1:0] rs2_q;
    logic [1:0]      a_sel_q;
    logic            b_imm_q;

    // Forwarded register values
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load-use detection. A load in EX has no data until after MEM, so a
    // decode-stage consumer of its rd must wait one cycle. Both source
    // indices are compared even when the instruction does not use rs2,
    // which can cause an extra stall. A flush discards the consumer, so
    // there is nothing left to stall for.
    always_comb begin
        hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0)
                       && ((ex_rd == id_rs1) || (ex_rd == id_rs2))
                       && !flush_i;
    end

    // Pipeline register. Reset, flush, and a load-use stall all load the
    // same all-zero bubble. Flush has priority over hold, so a killed
    // instruction cannot survive a downstream stall. Hold has priority over
    // the load-use bubble because a frozen stage must not lose the load.
    // When decode has no real instruction, its control bits are dropped.
    // This keeps later stages from acting on a stale decode.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i || (!hold_i && hazard_stall)) begin
            ex_valid       <= 1'b0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            ex_pc          <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            ex_rd          <= '0;
            ex_alu_control <= 5'b00000;
            a_sel_q        <= 2'b00;
            b_imm_q        <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_branch      <= 1'b0;
        end else if (!hold_i) begin
            ex_valid       <= id_valid;
            rs1_data_q     <= id_rs1_data;
            rs2_data_q     <= id_rs2_data;
            imm_q          <= id_imm;
            ex_pc          <= id_pc;
            rs1_q          <= id_rs1;
            rs2_q          <= id_rs2;
            ex_rd          <= id_rd;
            ex_alu_control <= id_alu_control;
            a_sel_q        <= id_a_sel;
            b_imm_q        <= id_b_imm;
            ex_reg_write   <= id_valid && id_reg_write;
            ex_mem_read    <= id_valid && id_mem_read;
            ex_mem_write   <= id_valid && id_mem_write;
            ex_branch      <= id_valid && id_branch;
        end
    end

    // Same-cycle forwarding on the registered source indices. EX/MEM is the
    // younger result, so it wins over MEM/WB. x0 is hardwired to zero and is
    // never forwarded, even if some stage claims to write it.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q))
            fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q))
            fwd_rs1 = memwb_result;

        fwd_rs2 = rs2_data_q;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q))
            fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q))
            fwd_rs2 = memwb_result;
    end

    // Operand selection. Operand A is rs1, PC (auipc/jal), or zero (lui).
    // Operand B is the immediate or rs2. Stores always need the real rs2
    // value, even when operand B carries the address offset.
    always_comb begin
        unique case (a_sel_q)
            2'b00:   ex_rd1 = fwd_rs1;
            2'b01:   ex_rd1 = ex_pc;
            default: ex_rd1 = '0;
        endcase
        ex_rd2        = b_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed test for id_ex_stage. It covers reset, basic capture, forwarding
// priority and x0 handling, load-use stall and recovery, flush versus hazard,
// hold, flush versus hold, immediate and PC operand select, and reset during
// a stall.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    logic            clk;
    logic            rst_n;
    logic            flush_i;
    logic            hold_i;
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [4:0]      id_alu_control;
    logic [1:0]      id_a_sel;
    logic            id_b_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;
    logic            exmem_reg_write;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;

    logic                   ex_valid;
    logic signed [XLEN-1:0] ex_rd1;
    logic signed [XLEN-1:0] ex_rd2;
    logic [4:0]             ex_alu_control;
    logic [XLEN-1:0]        ex_store_data;
    logic [XLEN-1:0]        ex_pc;
    logic [REGW-1:0]        ex_rd;
    logic                   ex_reg_write;
    logic                   ex_mem_read;
    logic                   ex_mem_write;
    logic                   ex_branch;
    logic                   hazard_stall;

    int compared   = 0;
    int mismatched = 0;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .hold_i          (hold_i),
        .id_valid        (id_valid),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_pc           (id_pc),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_alu_control  (id_alu_control),
        .id_a_sel        (id_a_sel),
        .id_b_imm        (id_b_imm),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_branch       (id_branch),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_rd1          (ex_rd1),
        .ex_rd2          (ex_rd2),
        .ex_alu_control  (ex_alu_control),
        .ex_store_data   (ex_store_data),
        .ex_pc           (ex_pc),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_branch       (ex_branch),
        .hazard_stall    (hazard_stall)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling or driving
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction onto the id_* inputs
    task automatic applyStimulus(
        input logic            valid,
        input logic [REGW-1:0] rs1,
        input logic [XLEN-1:0] rs1_data,
        input logic [REGW-1:0] rs2,
        input logic [XLEN-1:0] rs2_data,
        input logic [REGW-1:0] rd,
        input logic [4:0]      alu,
        input logic [1:0]      a_sel,
        input logic            b_imm,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] pc,
        input logic            reg_write,
        input logic            mem_read,
        input logic            mem_write,
        input logic            branch
    );
        id_valid       = valid;
        id_rs1         = rs1;
        id_rs1_data    = rs1_data;
        id_rs2         = rs2;
        id_rs2_data    = rs2_data;
        id_rd          = rd;
        id_alu_control = alu;
        id_a_sel       = a_sel;
        id_b_imm       = b_imm;
        id_imm         = imm;
        id_pc          = pc;
        id_reg_write   = reg_write;
        id_mem_read    = mem_read;
        id_mem_write   = mem_write;
        id_branch      = branch;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive a load "lw x4, 8(x1)" into EX
    task automatic loadLw4;
        applyStimulus(1'b1, 5'd1, 32'h100, 5'd0, 32'h0, 5'd4, 5'b00000, 2'b00, 1'b1,
                      32'h8, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        flush_i = 1'b0;
        hold_i = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

        // ---- Reset with nonzero decode inputs ----
        applyStimulus(1'b1, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 5'd3, 5'b10110, 2'b01, 1'b1,
                      32'hCCCC, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checkOutput("rst_valid",     ex_valid,       0);
        checkOutput("rst_rd1",       ex_rd1,         0);
        checkOutput("rst_rd2",       ex_rd2,         0);
        checkOutput("rst_store",     ex_store_data,  0);
        checkOutput("rst_alu",       ex_alu_control, 0);
        checkOutput("rst_pc",        ex_pc,          0);
        checkOutput("rst_rd",        ex_rd,          0);
        checkOutput("rst_ctrl",      {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 0);
        checkOutput("rst_stall",     hazard_stall,   0);

        // ---- Basic add x5 = x1 + x2 ----
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 5'b00000, 2'b00, 1'b0,
                      32'h0, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("add_valid", ex_valid,       1);
        checkOutput("add_rd1",   ex_rd1,         5);
        checkOutput("add_rd2",   ex_rd2,         7);
        checkOutput("add_alu",   ex_alu_control, 0);
        checkOutput("add_rd",    ex_rd,          5);
        checkOutput("add_regwr", ex_reg_write,   1);
        checkOutput("add_pc",    ex_pc,          32'h104);

        // ---- Forwarding priority on rs1 = x3, rs2 = x6 ----
        applyStimulus(1'b1, 5'd3, 32'h99, 5'd6, 32'h66, 5'd7, 5'b00010, 2'b00, 1'b0,
                      32'h0, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        #1;
        checkOutput("fwd_exmem_wins", ex_rd1, 32'h11);
        checkOutput("fwd_rs2_none",   ex_rd2, 32'h66);
        exmem_reg_write = 1'b0;
        #1;
        checkOutput("fwd_memwb",      ex_rd1, 32'h22);
        exmem_reg_write = 1'b1; exmem_rd = 5'd0;
        #1;
        checkOutput("fwd_exmem_x0",   ex_rd1, 32'h22);
        memwb_reg_write = 1'b0;
        #1;
        checkOutput("fwd_none",       ex_rd1, 32'h99);
        exmem_rd = 5'd6; exmem_result = 32'h6060;
        #1;
        checkOutput("fwd_store",      ex_store_data, 32'h6060);
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_rd = '0; memwb_result = '0;

        // ---- Load-use: lw x4 then add x7 = x5 + x4 ----
        loadLw4();
        applyStimulus(1'b1, 5'd5, 32'h55, 5'd4, 32'h4444, 5'd7, 5'b00000, 2'b00, 1'b0,
                      32'h0, 32'h304, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lu_stall",       hazard_stall, 1);
        tick();
        checkOutput("lu_bubble_valid", ex_valid,     0);
        checkOutput("lu_bubble_regwr", ex_reg_write, 0);
        checkOutput("lu_stall_clear",  hazard_stall, 0);
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hDEAD0000;
        tick();
        checkOutput("lu_fwd_rs2",   ex_rd2,   32'hDEAD0000);
        checkOutput("lu_rs1",       ex_rd1,   32'h55);
        checkOutput("lu_cons_rd",   ex_rd,    7);
        checkOutput("lu_cons_valid", ex_valid, 1);
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

        // ---- Flush together with a load-use condition ----
        loadLw4();
        applyStimulus(1'b1, 5'd4, 32'h0, 5'd0, 32'h0, 5'd9, 5'b00000, 2'b00, 1'b0,
                      32'h0, 32'h30C, 1'b1, 1'b0, 1'b0, 1'b0);
        flush_i = 1'b1;
        #1;
        checkOutput("flush_stall_off", hazard_stall, 0);
        tick();
        flush_i = 1'b0;
        checkOutput("flush_valid",   ex_valid,    0);
        checkOutput("flush_memread", ex_mem_read, 0);
        checkOutput("flush_rd",      ex_rd,       0);

        // ---- Hold for 3 cycles while decode changes ----
        applyStimulus(1'b1, 5'd8, 32'h80, 5'd9, 32'h90, 5'd10, 5'b00010, 2'b00, 1'b0,
                      32'h0, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(i + 11), 32'(i + 32'h500), 5'(i + 14), 32'h77, 5'(i + 20),
                          5'b11100, 2'b01, 1'b1, 32'hFFFF, 32'(32'h800 + i), 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        checkOutput("hold_pc",     ex_pc,          32'h400);
        checkOutput("hold_alu",    ex_alu_control, 5'b00010);
        checkOutput("hold_rd",     ex_rd,          10);
        checkOutput("hold_rd1",    ex_rd1,         32'h80);
        checkOutput("hold_ctrl",   {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 4'b1001);
        exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_result = 32'h999;
        #1;
        checkOutput("hold_fwd_rd2",   ex_rd2,        32'h999);
        checkOutput("hold_fwd_store", ex_store_data, 32'h999);
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;

        // ---- Flush together with hold ----
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        hold_i = 1'b0;
        checkOutput("flushhold_valid", ex_valid, 0);
        checkOutput("flushhold_pc",    ex_pc,    0);

        // ---- LUI: operand A zero, operand B immediate ----
        applyStimulus(1'b1, 5'd3, 32'hAAAA, 5'd0, 32'h0, 5'd12, 5'b11111, 2'b10, 1'b1,
                      32'h12345000, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("lui_rd1", ex_rd1,         0);
        checkOutput("lui_rd2", ex_rd2,         32'h12345000);
        checkOutput("lui_alu", ex_alu_control, 5'b11111);

        // ---- AUIPC-style: operand A is PC ----
        applyStimulus(1'b1, 5'd3, 32'hAAAA, 5'd2, 32'h0, 5'd13, 5'b00000, 2'b01, 1'b1,
                      32'h1000, 32'h2000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("auipc_rd1", ex_rd1, 32'h2000);

        // ---- Invalid decode slot drops control bits ----
        applyStimulus(1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd14, 5'b00000, 2'b00, 1'b0,
                      32'h0, 32'h2004, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("inv_ctrl", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 0);

        // ---- Reset in the middle of a stall ----
        loadLw4();
        applyStimulus(1'b1, 5'd4, 32'h0, 5'd0, 32'h0, 5'd9, 5'b00000, 2'b00, 1'b0,
                      32'h0, 32'h30C, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rststall_pre", hazard_stall, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("rststall_valid", ex_valid,     0);
        checkOutput("rststall_stall", hazard_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
